regfile: RTL
============

# regfile

General-purpose register file for the five-stage MIPS pipeline: 32 × 32-bit registers with two asynchronous read ports and one synchronous write port. It is the responder to the decode stage's register-read requests (read enable + register number in, operand data out). The write-back stage drives its write port. It also provides write-to-read bypass within the same cycle, so the decode stage never sees a stale value for a register being written that cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, register-number width
- `NUM_REGS`, 32, number of registers (= 2^ADDR_WIDTH)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `we`  in  1  write enable from write-back stage
- `waddr`  in  ADDR_WIDTH  destination register number
- `wdata`  in  DATA_WIDTH  write data
- `re1`  in  1  read-port-1 enable from decode
- `raddr1`  in  ADDR_WIDTH  read-port-1 register number
- `rdata1`  out  DATA_WIDTH  read-port-1 data (combinational)
- `re2`  in  1  read-port-2 enable from decode
- `raddr2`  in  ADDR_WIDTH  read-port-2 register number
- `rdata2`  out  DATA_WIDTH  read-port-2 data (combinational)

## Operation
- Storage: array `regs[0..NUM_REGS-1]`, each DATA_WIDTH bits.
- Register 0 is hardwired zero:
  - A write with `waddr`=0 is discarded; storage for entry 0 is never modified.
  - A read of address 0 always returns 0, including when a bypass condition matches.
- Write, on the rising edge of `clk`:
  - If `rst`=1: every entry is cleared to 0, and any write in that cycle is ignored.
  - Else if `we`=1 and `waddr`≠0: `regs[waddr]` ← `wdata`.
- Read, port n (identical logic for ports 1 and 2), priority order:
  1. `rst`=1 → `rdataN` = 0
  2. `reN`=0 → `rdataN` = 0
  3. `raddrN`=0 → `rdataN` = 0
  4. `we`=1 and `waddr`=`raddrN` → `rdataN` = `wdata` (bypass)
  5. otherwise → `rdataN` = `regs[raddrN]`
- Both ports are independent. The same address on both ports returns identical data, and both ports may bypass in the same cycle.
- No arithmetic. Data passes through unmodified at full DATA_WIDTH, with no sign or zero extension.

## Timing
- Read latency: 0 cycles, purely combinational from `reN`, `raddrN`, `we`, `waddr`, `wdata` and stored state.
- Write latency: 1 edge. The value is visible through storage from the cycle after the edge, and through bypass during the write cycle itself.
- Reset values:
  - All registers are 0 after the first rising edge with `rst`=1.
  - `rdata1` and `rdata2` are 0 whenever `rst`=1, regardless of other inputs.
- Reset mid-operation: a write presented in a cycle with `rst`=1 is lost. It is neither stored nor bypassed, and the first cycle after reset reads 0 from every register.
- Simultaneous events:
  - A write and two reads of the same register in one cycle: both ports return `wdata`, and storage updates at the edge.
  - A write to register 0 together with a read of register 0: the read returns 0.
- No handshake and no stall. Every access completes in its cycle, so there is no backpressure to decode or write-back.
- Write data and address must be stable before the rising edge (setup). Read outputs settle within the same cycle for the decode-stage operand mux.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, assert `rst` for 1 cycle, deassert, read r5 on port 1 → `rdata1`=0x00000000. While `rst`=1, both outputs are 0 even with `re1`=`re2`=1.
- Write/read-back: write r1=0x12345678 and r31=0xFFFFFFFF on successive cycles; the following cycle, read port 1=r1, port 2=r31 → 0x12345678 and 0xFFFFFFFF.
- Zero register: `we`=1, `waddr`=0, `wdata`=0xAAAAAAAA, with `re1`=1, `raddr1`=0 in the same cycle → `rdata1`=0. The next cycle's read of r0 → 0.
- Bypass: r7 holds 0x11111111. In one cycle set `we`=1, `waddr`=7, `wdata`=0x22222222, and read r7 on both ports → both outputs 0x22222222 that cycle. The next cycle, with `we`=0 → both 0x22222222 from storage.
- Read-enable gating: r3=0x0BADF00D, `re1`=0, `raddr1`=3 → `rdata1`=0. Raise `re1`=1 → `rdata1`=0x0BADF00D.
- Reset vs write: in the same cycle `rst`=1, `we`=1, `waddr`=9, `wdata`=0x55555555. Deassert reset and read r9 → 0.

Source files
------------

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the five-stage MIPS pipeline.
// NUM_REGS x DATA_WIDTH storage, two combinational read ports serving the
// decode stage and one synchronous write port driven by write-back.
// Register 0 reads as zero and ignores writes. A write presented in the same
// cycle as a read of the same register is forwarded to the read port, so
// decode never sees a stale operand.
//
// Ports:
//   clk     in   1           clock, all state updates on the rising edge
//   rst     in   1           synchronous active-high reset, clears all entries
//   we      in   1           write enable (write-back stage)
//   waddr   in   ADDR_WIDTH  destination register number
//   wdata   in   DATA_WIDTH  write data
//   re1     in   1           read-port-1 enable (decode stage)
//   raddr1  in   ADDR_WIDTH  read-port-1 register number
//   rdata1  out  DATA_WIDTH  read-port-1 data, combinational
//   re2     in   1           read-port-2 enable (decode stage)
//   raddr2  in   ADDR_WIDTH  read-port-2 register number
//   rdata2  out  DATA_WIDTH  read-port-2 data, combinational
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write to r0 is never committed, so entry 0 keeps its reset value.
  logic wr_commit;
  assign wr_commit = we && (waddr != '0);

  // NOTE: this storage is cleared on reset because the pipeline relies on
  // every register reading 0 after reset; the per-entry reset is what turns it
  // into flops instead of a plain RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[waddr] <= wdata;
    end
  end

  // Read-port selection in priority order: reset, enable, r0, bypass, storage.
  // The bypass uses the raw write enable; a write to r0 cannot leak through
  // because the r0 check wins first.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  rst_i,
    input logic                  re_i,
    input logic [ADDR_WIDTH-1:0] raddr_i,
    input logic                  we_i,
    input logic [ADDR_WIDTH-1:0] waddr_i,
    input logic [DATA_WIDTH-1:0] wdata_i,
    input logic [DATA_WIDTH-1:0] stored_i
  );
    logic [DATA_WIDTH-1:0] result;
    if (rst_i || !re_i || (raddr_i == '0)) begin
      result = '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      result = wdata_i;
    end else begin
      result = stored_i;
    end
    return result;
  endfunction

  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, regs[raddr1]);
    rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, regs[raddr2]);
  end

endmodule
